// File: rtl/lzw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lzw_pkg
// Brief    : Shared LZW dictionary constants and entry layout, used by the
//            dictionary RAM and the compressor/decompressor control FSM.
// Revision : 1.0 - initial release
// ============================================================================
package lzw_pkg;

    localparam int DICT_DEPTH = 2048;
    localparam int CODE_W     = $clog2(DICT_DEPTH);
    localparam int FIRST_CODE = 256;
    localparam int ENTRY_W    = 64;
    localparam int SUFFIX_W   = 8;
    localparam int PAD_W      = ENTRY_W - CODE_W - SUFFIX_W;

    // One dictionary entry: the code of the prefix string plus the byte
    // that extends it. The upper bits are spare.
    typedef struct packed {
        logic [PAD_W-1:0]    pad;
        logic [CODE_W-1:0]   prefix;
        logic [SUFFIX_W-1:0] suffix;
    } lzw_entry_t;

    function automatic lzw_entry_t make_entry(input logic [CODE_W-1:0]   prefix,
                                              input logic [SUFFIX_W-1:0] suffix);
        lzw_entry_t e;
        e.pad    = '0;
        e.prefix = prefix;
        e.suffix = suffix;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lzw_dict_ram_if.sv
`default_nettype none
// ============================================================================
// Module   : lzw_dict_ram_if
// Brief    : Append / overwrite / read bus of the LZW dictionary RAM.
//            master = control FSM side, slave = dictionary side.
// Revision : 1.0 - initial release
// ============================================================================
interface lzw_dict_ram_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 11
) ();

    logic              cs;
    logic              clr;
    logic              app_en;
    logic [DATA_W-1:0] app_data;
    logic [ADDR_W-1:0] app_code;
    logic              full;
    logic              app_ovf;
    logic              we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              re;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_hit;

    modport master (
        output cs, clr, app_en, app_data, we, w_addr, w_data, re, r_addr,
        input  app_code, full, app_ovf, r_data, r_valid, r_hit
    );

    modport slave (
        input  cs, clr, app_en, app_data, we, w_addr, w_data, re, r_addr,
        output app_code, full, app_ovf, r_data, r_valid, r_hit
    );

endinterface
`default_nettype wire

// File: rtl/lzw_dict_bram.sv
`default_nettype none
// ============================================================================
// Module   : lzw_dict_bram
// Brief    : Dictionary storage array. Two write ports (append and overwrite
//            can retire in the same cycle), one synchronous read port, and an
//            optional output register when RD_LATENCY is 2. The array and the
//            data registers are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module lzw_dict_bram #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 2048,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int RD_LATENCY = 2
) (
    input  wire logic              clk,
    input  wire logic              we_a,
    input  wire logic [ADDR_W-1:0] addr_a,
    input  wire logic [DATA_W-1:0] din_a,
    input  wire logic              we_b,
    input  wire logic [ADDR_W-1:0] addr_b,
    input  wire logic [DATA_W-1:0] din_b,
    input  wire logic              rd_en,
    input  wire logic [ADDR_W-1:0] rd_addr,
    output logic      [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] r_q1;

    // Write both ports; the caller guarantees they never collide.
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
    end

    // Synchronous read; holds its value between reads.
    always_ff @(posedge clk) begin
        if (rd_en) r_q1 <= mem[rd_addr];
    end

    generate
        if (RD_LATENCY == 2) begin : g_oreg
            logic [DATA_W-1:0] r_q2;
            // Output register follows the read register every cycle, so it
            // also holds once reads stop.
            always_ff @(posedge clk) begin
                r_q2 <= r_q1;
            end
            assign q = r_q2;
        end else begin : g_no_oreg
            assign q = r_q1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/lzw_dict_ram.sv
`default_nettype none
// ============================================================================
// Module   : lzw_dict_ram
// Brief    : LZW dictionary memory: allocation counter, per-entry valid
//            bitmap with single-cycle clear, write-first forwarding and a
//            1- or 2-cycle read pipeline around lzw_dict_bram.
// Revision : 1.0 - initial release
// ============================================================================
module lzw_dict_ram #(
    parameter int DATA_W     = lzw_pkg::ENTRY_W,
    parameter int DEPTH      = lzw_pkg::DICT_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int FIRST_CODE = lzw_pkg::FIRST_CODE,
    parameter int RD_LATENCY = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    lzw_dict_ram_if.slave bus
);

    import lzw_pkg::*;

    localparam logic [ADDR_W:0] c_first = (ADDR_W+1)'(FIRST_CODE);
    localparam logic [ADDR_W:0] c_full  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);

    logic [ADDR_W:0]   r_next_code;
    logic              r_app_ovf;
    logic [DEPTH-1:0]  r_vmap;
    logic [ADDR_W-1:0] w_app_addr;
    logic              w_full;
    logic              w_app;
    logic              w_ovr;
    logic              w_rd;
    logic              w_app_hit;
    logic              w_ovr_hit;
    logic              w_fwd_now;
    logic              w_hit_now;
    logic [DATA_W-1:0] w_fwd_data;

    logic              r_s1_v;
    logic              r_s1_hit;
    logic              r_s1_fwd;
    logic [DATA_W-1:0] r_s1_fwd_data;
    logic              w_out_v;
    logic              w_out_hit;
    logic              w_out_fwd;
    logic [DATA_W-1:0] w_out_fwd_data;
    logic [DATA_W-1:0] w_bram_q;
    logic              r_seen;

    assign w_app_addr = r_next_code[ADDR_W-1:0];
    assign w_full     = (r_next_code == c_full);
    assign w_app      = bus.cs & bus.app_en & ~bus.clr & ~w_full;
    // An overwrite aimed at the code being appended this cycle is dropped.
    assign w_ovr      = bus.cs & bus.we & ~bus.clr &
                        ~(w_app & (bus.w_addr == w_app_addr));
    assign w_rd       = bus.cs & bus.re;
    assign w_app_hit  = w_app & (w_app_addr == bus.r_addr);
    assign w_ovr_hit  = w_ovr & (bus.w_addr == bus.r_addr);

    // Write-first: a same-cycle write to the read address supplies the data
    // and counts as a hit; clear forces a miss.
    always_comb begin
        w_fwd_now  = w_app_hit | w_ovr_hit;
        w_fwd_data = w_app_hit ? bus.app_data : bus.w_data;
        w_hit_now  = ~bus.clr & (r_vmap[bus.r_addr] | w_fwd_now);
    end

    // Allocation counter and overflow pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_next_code <= c_first;
            r_app_ovf   <= 1'b0;
        end else begin
            r_app_ovf <= bus.cs & bus.app_en & ~bus.clr & w_full;
            if (bus.clr)
                r_next_code <= c_first;
            else if (w_app)
                r_next_code <= r_next_code + c_one;
        end
    end

    // Valid bitmap: cleared in one cycle, set by every retired write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vmap <= '0;
        end else if (bus.clr) begin
            r_vmap <= '0;
        end else begin
            if (w_app) r_vmap[w_app_addr] <= 1'b1;
            if (w_ovr) r_vmap[bus.w_addr] <= 1'b1;
        end
    end

    lzw_dict_bram #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .RD_LATENCY (RD_LATENCY)
    ) u_bram (
        .clk     (clk),
        .we_a    (w_app),
        .addr_a  (w_app_addr),
        .din_a   (bus.app_data),
        .we_b    (w_ovr),
        .addr_b  (bus.w_addr),
        .din_b   (bus.w_data),
        .rd_en   (w_rd),
        .rd_addr (bus.r_addr),
        .q       (w_bram_q)
    );

    // First read stage: strobe, hit and forwarding info alongside the RAM read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_v        <= 1'b0;
            r_s1_hit      <= 1'b0;
            r_s1_fwd      <= 1'b0;
            r_s1_fwd_data <= '0;
        end else begin
            r_s1_v <= w_rd;
            if (w_rd) begin
                r_s1_hit      <= w_hit_now;
                r_s1_fwd      <= w_fwd_now;
                r_s1_fwd_data <= w_fwd_data;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic              r_s2_v;
            logic              r_s2_hit;
            logic              r_s2_fwd;
            logic [DATA_W-1:0] r_s2_fwd_data;
            // Second stage tracks the RAM output register.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_s2_v        <= 1'b0;
                    r_s2_hit      <= 1'b0;
                    r_s2_fwd      <= 1'b0;
                    r_s2_fwd_data <= '0;
                end else begin
                    r_s2_v        <= r_s1_v;
                    r_s2_hit      <= r_s1_hit;
                    r_s2_fwd      <= r_s1_fwd;
                    r_s2_fwd_data <= r_s1_fwd_data;
                end
            end
            assign w_out_v        = r_s2_v;
            assign w_out_hit      = r_s2_hit;
            assign w_out_fwd      = r_s2_fwd;
            assign w_out_fwd_data = r_s2_fwd_data;
        end else begin : g_lat1
            assign w_out_v        = r_s1_v;
            assign w_out_hit      = r_s1_hit;
            assign w_out_fwd      = r_s1_fwd;
            assign w_out_fwd_data = r_s1_fwd_data;
        end
    endgenerate

    // Remembers that a read has completed since reset, so r_data reads as 0
    // until the (unreset) RAM output carries real data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_seen <= 1'b0;
        else if (w_out_v)
            r_seen <= 1'b1;
    end

    assign bus.r_data   = (w_out_v | r_seen) ?
                          (w_out_fwd ? w_out_fwd_data : w_bram_q) : '0;
    assign bus.r_valid  = w_out_v;
    assign bus.r_hit    = w_out_hit;
    assign bus.app_code = w_app_addr;
    assign bus.full     = w_full;
    assign bus.app_ovf  = r_app_ovf;

endmodule
`default_nettype wire

// File: tb/tb_lzw_dict_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_lzw_dict_ram
// Brief    : Directed bench for lzw_dict_ram. dut_a uses the default
//            2048-entry, 2-cycle-latency build; dut_b a 512-entry,
//            1-cycle-latency build for the full/overflow and short-latency
//            cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lzw_dict_ram;

    import lzw_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    lzw_dict_ram_if #(.DATA_W(64), .ADDR_W(11)) bus_a ();
    lzw_dict_ram_if #(.DATA_W(64), .ADDR_W(9))  bus_b ();

    lzw_dict_ram #(
        .DATA_W(64), .DEPTH(2048), .ADDR_W(11), .FIRST_CODE(256), .RD_LATENCY(2)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    lzw_dict_ram #(
        .DATA_W(64), .DEPTH(512), .ADDR_W(9), .FIRST_CODE(256), .RD_LATENCY(1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic a_clear();
        bus_a.app_en = 1'b0;
        bus_a.we     = 1'b0;
        bus_a.re     = 1'b0;
        bus_a.clr    = 1'b0;
    endtask

    task automatic b_clear();
        bus_b.app_en = 1'b0;
        bus_b.we     = 1'b0;
        bus_b.re     = 1'b0;
        bus_b.clr    = 1'b0;
    endtask

    // Caller has set up a read on dut_a; result lands two cycles later.
    task automatic a_issue(input string tag, input bit chk_data,
                           input logic [63:0] exp_data, input logic exp_hit);
        @(negedge clk);
        a_clear();
        check({tag, "_early"}, {63'd0, bus_a.r_valid}, 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, {63'd0, bus_a.r_valid}, 64'd1);
        check({tag, "_hit"},   {63'd0, bus_a.r_hit},   {63'd0, exp_hit});
        if (chk_data) check({tag, "_data"}, bus_a.r_data, exp_data);
    endtask

    // Caller has set up a read on dut_b; result lands one cycle later.
    task automatic b_issue(input string tag, input logic [63:0] exp_data, input logic exp_hit);
        @(negedge clk);
        b_clear();
        check({tag, "_valid"}, {63'd0, bus_b.r_valid}, 64'd1);
        check({tag, "_hit"},   {63'd0, bus_b.r_hit},   {63'd0, exp_hit});
        check({tag, "_data"},  bus_b.r_data, exp_data);
        @(negedge clk);
        check({tag, "_once"},  {63'd0, bus_b.r_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 required");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        a_clear(); b_clear();
        bus_a.cs = 1'b0; bus_a.app_data = '0; bus_a.w_addr = '0; bus_a.w_data = '0; bus_a.r_addr = '0;
        bus_b.cs = 1'b0; bus_b.app_data = '0; bus_b.w_addr = '0; bus_b.w_data = '0; bus_b.r_addr = '0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_code",   {53'd0, bus_a.app_code}, 64'd256);
        check("rst_full",   {63'd0, bus_a.full},     64'd0);
        check("rst_ovf",    {63'd0, bus_a.app_ovf},  64'd0);
        check("rst_rvalid", {63'd0, bus_a.r_valid},  64'd0);
        check("rst_rhit",   {63'd0, bus_a.r_hit},    64'd0);
        check("rst_rdata",  bus_a.r_data,            64'd0);
        check("rst_code_b", {55'd0, bus_b.app_code}, 64'd256);
        rst = 1'b1;
        @(negedge clk);
        bus_a.cs = 1'b1;
        bus_b.cs = 1'b1;

        // ---- back-to-back appends ----
        check("app0_code", {53'd0, bus_a.app_code}, 64'd256);
        bus_a.app_en   = 1'b1;
        bus_a.app_data = make_entry(11'h042, 8'h41);
        @(negedge clk);
        check("app1_code", {53'd0, bus_a.app_code}, 64'd257);
        bus_a.app_data = 64'h4142;
        @(negedge clk);
        check("app2_code", {53'd0, bus_a.app_code}, 64'd258);
        bus_a.app_data = 64'h41;
        @(negedge clk);
        check("app3_code", {53'd0, bus_a.app_code}, 64'd259);
        a_clear();

        // ---- pipelined reads of 256 and 258 ----
        bus_a.re = 1'b1; bus_a.r_addr = 11'd256;
        @(negedge clk);
        bus_a.r_addr = 11'd258;
        check("rd256_early", {63'd0, bus_a.r_valid}, 64'd0);
        @(negedge clk);
        a_clear();
        check("rd256_valid", {63'd0, bus_a.r_valid}, 64'd1);
        check("rd256_data",  bus_a.r_data,           64'h4241);
        check("rd256_hit",   {63'd0, bus_a.r_hit},   64'd1);
        @(negedge clk);
        check("rd258_valid", {63'd0, bus_a.r_valid}, 64'd1);
        check("rd258_data",  bus_a.r_data,           64'h41);
        check("rd258_hit",   {63'd0, bus_a.r_hit},   64'd1);
        @(negedge clk);
        check("idle_valid",  {63'd0, bus_a.r_valid}, 64'd0);
        check("idle_hold",   bus_a.r_data,           64'h41);

        // ---- unwritten code, then overwrite above next_code ----
        bus_a.re = 1'b1; bus_a.r_addr = 11'h483;
        a_issue("rd483_empty", 1'b0, 64'd0, 1'b0);
        bus_a.we = 1'b1; bus_a.w_addr = 11'h483; bus_a.w_data = 64'h4241;
        @(negedge clk);
        a_clear();
        check("ovr_code", {53'd0, bus_a.app_code}, 64'd259);
        bus_a.re = 1'b1; bus_a.r_addr = 11'h483;
        a_issue("rd483", 1'b1, 64'h4241, 1'b1);

        // ---- read-during-overwrite, write-first ----
        bus_a.we = 1'b1; bus_a.w_addr = 11'h485; bus_a.w_data = 64'h1234;
        bus_a.re = 1'b1; bus_a.r_addr = 11'h485;
        a_issue("rdw485", 1'b1, 64'h1234, 1'b1);

        // ---- append and overwrite to the same code: append wins ----
        bus_a.app_en = 1'b1; bus_a.app_data = 64'hAAAA;
        bus_a.we = 1'b1; bus_a.w_addr = 11'd259; bus_a.w_data = 64'hBBBB;
        bus_a.re = 1'b1; bus_a.r_addr = 11'd259;
        a_issue("same_fwd", 1'b1, 64'hAAAA, 1'b1);
        check("same_code", {53'd0, bus_a.app_code}, 64'd260);
        bus_a.re = 1'b1; bus_a.r_addr = 11'd259;
        a_issue("same_reread", 1'b1, 64'hAAAA, 1'b1);

        // ---- append and overwrite to different codes: both land ----
        bus_a.app_en = 1'b1; bus_a.app_data = 64'h1111;
        bus_a.we = 1'b1; bus_a.w_addr = 11'h300; bus_a.w_data = 64'h2222;
        @(negedge clk);
        a_clear();
        check("diff_code", {53'd0, bus_a.app_code}, 64'd261);
        bus_a.re = 1'b1; bus_a.r_addr = 11'd260;
        a_issue("diff_app", 1'b1, 64'h1111, 1'b1);
        bus_a.re = 1'b1; bus_a.r_addr = 11'h300;
        a_issue("diff_ovr", 1'b1, 64'h2222, 1'b1);

        // ---- clear together with append and read ----
        bus_a.clr = 1'b1; bus_a.app_en = 1'b1; bus_a.app_data = 64'h5555;
        bus_a.re = 1'b1; bus_a.r_addr = 11'd257;
        @(negedge clk);
        a_clear();
        check("clr_code", {53'd0, bus_a.app_code}, 64'd256);
        @(negedge clk);
        check("clr_rd_valid", {63'd0, bus_a.r_valid}, 64'd1);
        check("clr_rd_hit",   {63'd0, bus_a.r_hit},   64'd0);
        check("clr_rd_data",  bus_a.r_data,           64'h4142);
        bus_a.re = 1'b1; bus_a.r_addr = 11'd256;
        a_issue("clr_rd256", 1'b1, 64'h4241, 1'b0);
        bus_a.re = 1'b1; bus_a.r_addr = 11'h483;
        a_issue("clr_rd483", 1'b0, 64'd0, 1'b0);
        bus_a.re = 1'b1; bus_a.r_addr = 11'h300;
        a_issue("clr_rd300", 1'b0, 64'd0, 1'b0);
        bus_a.app_en = 1'b1; bus_a.app_data = 64'h7777;
        @(negedge clk);
        a_clear();
        check("post_clr_code", {53'd0, bus_a.app_code}, 64'd257);
        bus_a.re = 1'b1; bus_a.r_addr = 11'd256;
        a_issue("post_clr_rd", 1'b1, 64'h7777, 1'b1);

        // ---- reset in the middle of a four-read burst ----
        bus_a.re = 1'b1; bus_a.r_addr = 11'd256;
        @(negedge clk); bus_a.r_addr = 11'd257;
        @(negedge clk); bus_a.r_addr = 11'd258;
        @(negedge clk); bus_a.r_addr = 11'd259;
        #2 rst = 1'b0;
        @(negedge clk);
        a_clear();
        check("rstm_valid", {63'd0, bus_a.r_valid},  64'd0);
        check("rstm_code",  {53'd0, bus_a.app_code}, 64'd256);
        rst = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus_a.r_valid) seen++;
        end
        check("rstm_no_valid", 64'(seen), 64'd0);
        check("rstm_code_after", {53'd0, bus_a.app_code}, 64'd256);

        // ---- dut_b: chip select gates read and append ----
        bus_b.cs = 1'b0; bus_b.re = 1'b1; bus_b.r_addr = 9'd5;
        bus_b.app_en = 1'b1; bus_b.app_data = 64'h99;
        @(negedge clk);
        b_clear();
        bus_b.cs = 1'b1;
        check("b_cs0_valid", {63'd0, bus_b.r_valid},  64'd0);
        check("b_cs0_code",  {55'd0, bus_b.app_code}, 64'd256);

        // ---- dut_b: read-during-overwrite at one-cycle latency ----
        bus_b.we = 1'b1; bus_b.w_addr = 9'h085; bus_b.w_data = 64'h1234;
        bus_b.re = 1'b1; bus_b.r_addr = 9'h085;
        b_issue("b_rdw85", 64'h1234, 1'b1);

        // ---- dut_b: fill, then overflow ----
        bus_b.we = 1'b1; bus_b.w_addr = 9'd0; bus_b.w_data = 64'h5A5A;
        @(negedge clk);
        b_clear();
        bus_b.app_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus_b.app_data = 64'(256 + i);
            if (i == 255) check("b_full_early", {63'd0, bus_b.full}, 64'd0);
            @(negedge clk);
        end
        b_clear();
        check("b_full",      {63'd0, bus_b.full},     64'd1);
        check("b_full_code", {55'd0, bus_b.app_code}, 64'd0);
        check("b_ovf_quiet", {63'd0, bus_b.app_ovf},  64'd0);
        bus_b.app_en = 1'b1; bus_b.app_data = 64'hDEAD;
        @(negedge clk);
        b_clear();
        check("b_ovf_pulse", {63'd0, bus_b.app_ovf},  64'd1);
        check("b_ovf_code",  {55'd0, bus_b.app_code}, 64'd0);
        @(negedge clk);
        check("b_ovf_end",   {63'd0, bus_b.app_ovf},  64'd0);
        bus_b.re = 1'b1; bus_b.r_addr = 9'd0;
        b_issue("b_rd0", 64'h5A5A, 1'b1);
        bus_b.re = 1'b1; bus_b.r_addr = 9'd511;
        b_issue("b_rd511", 64'd511, 1'b1);
        bus_b.re = 1'b1; bus_b.r_addr = 9'd300;
        b_issue("b_rd300", 64'd300, 1'b1);

        // ---- dut_b: clear leaves the full state ----
        bus_b.clr = 1'b1;
        @(negedge clk);
        b_clear();
        check("b_clr_full", {63'd0, bus_b.full},     64'd0);
        check("b_clr_code", {55'd0, bus_b.app_code}, 64'd256);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
